// File: rtl/ahb_apb_bridge_ms_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ahb_apb_pkg;

  localparam int APB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
  } state_e;

  // One-hot select for a 4-bit slot field; callers truncate to their slot count.
  function automatic logic [15:0] slot_onehot(input logic [3:0] slot);
    return 16'h0001 << slot;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge_ms_apb_wait_timer.sv
// APB access stall timer: counts ACCESS cycles with PREADY low and flags the abort cycle.
// Latency: expire_o is combinational from en_i/count, for use in the FSM next-state logic only.
// Backpressure: none; TIMEOUT == 0 disables the abort entirely.
// Ports: clk, rst_n (async active-low), clr_i (zero the count), en_i (stalled ACCESS cycle),
//        expire_o (this stalled cycle is the TIMEOUT-th one).
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [15:0] LAST     = 16'(LAST_INT);
  localparam bit          ENABLED  = (TIMEOUT != 0);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      // Free-runs (and may wrap) when disabled; the compare is gated off then.
      count_d = count_q + 16'd1;
    end
  end

  // Count still holds the number of earlier stalled cycles, so LAST means this is stall #TIMEOUT.
  assign expire_o = ENABLED && en_i && (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_ms.sv
// AHB-Lite slave to APB3 master bridge with slot decode, PSLVERR/timeout error mapping.
// Latency: 3 AHB wait states for a zero-wait APB slave, +1 per PREADY-low ACCESS cycle.
// Backpressure: HREADYOUT low from LATCH through ACCESS (and ERR1); APB side stalls via PREADY.
// Ports: AHB slave side (HSEL, HREADYIN, HADDR, HTRANS, HWRITE, HWDATA -> HREADYOUT, HRESP, HRDATA),
//        APB master side (PSEL, PADDR, PWRITE, PENABLE, PWDATA <- PRDATA, PREADY, PSLVERR),
//        TIMEOUT_EVT single-cycle abort pulse. All outputs come straight from flops.
module ahb_apb_bridge_ms
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SLOT_LSB   = 24,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [APB_DATA_W-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [APB_DATA_W-1:0] HRDATA,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  TIMEOUT_EVT
);

  localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

  state_e                  state_q, state_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic [APB_DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic                    penable_q, penable_d;
  logic [APB_DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                    timeout_evt_q, timeout_evt_d;

  logic                    accept;
  logic [3:0]              slot;
  logic                    slot_err;
  logic [NUM_SLAVES-1:0]   slot_psel;
  logic                    timer_clr;
  logic                    timer_en;
  logic                    timer_expire;

  // Only NONSEQ/SEQ start a transfer; IDLE/BUSY get the default zero-wait OKAY.
  assign accept = HSEL && HREADYIN && !((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_BUSY));

  // Decode from the registered address so the slot check lands in LATCH.
  assign slot      = paddr_q[SLOT_LSB +: 4];
  assign slot_err  = ({1'b0, slot} >= NUM_SLAVES_W);
  assign slot_psel = NUM_SLAVES'(slot_onehot(slot));

  // Counter restarts for every access as the FSM leaves SETUP.
  assign timer_clr = (state_q == ST_SETUP);
  assign timer_en  = (state_q == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (HCLK),
    .rst_n    (HRESETN),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d       = state_q;
    hreadyout_d   = hreadyout_q;
    hresp_d       = hresp_q;
    hrdata_d      = hrdata_q;
    psel_d        = psel_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    penable_d     = penable_q;
    pwdata_d      = pwdata_q;
    timeout_evt_d = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for the next address phase, giving back-to-back transfers.
      ST_IDLE, ST_DONE: begin
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        state_d     = ST_IDLE;
        if (accept) begin
          state_d     = ST_LATCH;
          paddr_d     = HADDR;
          pwrite_d    = HWRITE;
          hreadyout_d = 1'b0;
        end
      end

      ST_LATCH: begin
        // Data phase: HWDATA is valid now; capturing it on reads is harmless.
        pwdata_d = HWDATA;
        if (slot_err) begin
          state_d = ST_ERR1;
          hresp_d = HRESP_ERROR;
          if (!pwrite_q) hrdata_d = '0;
        end else begin
          state_d = ST_SETUP;
          psel_d  = slot_psel;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        // PREADY is checked first so a response on the timeout cycle still completes normally.
        if (PREADY) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (PSLVERR) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
            if (!pwrite_q) hrdata_d = '0;
          end else begin
            state_d     = ST_DONE;
            hreadyout_d = 1'b1;
            if (!pwrite_q) hrdata_d = PRDATA;
          end
        end else if (timer_expire) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          state_d       = ST_ERR1;
          hresp_d       = HRESP_ERROR;
          timeout_evt_d = 1'b1;
          if (!pwrite_q) hrdata_d = '0;
        end
      end

      ST_ERR1: begin
        state_d     = ST_ERR2;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_ERROR;
      end

      // The master cancels whatever it presents here, so no transfer is accepted.
      ST_ERR2: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
      end

      default: begin
        state_d     = ST_IDLE;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        psel_d      = '0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q       <= ST_IDLE;
      hreadyout_q   <= 1'b1;
      hresp_q       <= HRESP_OKAY;
      hrdata_q      <= '0;
      psel_q        <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      penable_q     <= 1'b0;
      pwdata_q      <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hreadyout_q   <= hreadyout_d;
      hresp_q       <= hresp_d;
      hrdata_q      <= hrdata_d;
      psel_q        <= psel_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      penable_q     <= penable_d;
      pwdata_q      <= pwdata_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign HREADYOUT   = hreadyout_q;
  assign HRESP       = hresp_q;
  assign HRDATA      = hrdata_q;
  assign PSEL        = psel_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PENABLE     = penable_q;
  assign PWDATA      = pwdata_q;
  assign TIMEOUT_EVT = timeout_evt_q;

endmodule

// File: tb/tb_ahb_apb_bridge_ms.sv
// Bench for ahb_apb_bridge_ms: instance A (4 slots, TIMEOUT=8), instance B (16 slots, TIMEOUT=0).
// Table-driven transfers with a scoreboard queue, plus hand sequences for multi-cycle corners.
// Inputs driven and outputs sampled on the falling edge of HCLK.
module tb_ahb_apb_bridge_ms;
  import ahb_apb_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hsel, hreadyin, hwrite, pready, pslverr;
  logic [31:0] haddr, hwdata, prdata;
  logic [1:0]  htrans;

  logic        hro_a, hresp_a, pwrite_a, penable_a, tevt_a;
  logic [31:0] hrdata_a, paddr_a, pwdata_a;
  logic [3:0]  psel_a;

  logic        hro_b, hresp_b, pwrite_b, penable_b, tevt_b;
  logic [31:0] hrdata_b, paddr_b, pwdata_b;
  logic [15:0] psel_b;

  ahb_apb_bridge_ms #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .SLOT_LSB(24), .TIMEOUT(8)) u_dut_a (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel), .HREADYIN(hreadyin), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HREADYOUT(hro_a), .HRESP(hresp_a),
    .HRDATA(hrdata_a), .PSEL(psel_a), .PADDR(paddr_a), .PWRITE(pwrite_a), .PENABLE(penable_a),
    .PWDATA(pwdata_a), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .TIMEOUT_EVT(tevt_a)
  );

  ahb_apb_bridge_ms #(.NUM_SLAVES(16), .ADDR_WIDTH(32), .SLOT_LSB(24), .TIMEOUT(0)) u_dut_b (
    .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel), .HREADYIN(hreadyin), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HREADYOUT(hro_b), .HRESP(hresp_b),
    .HRDATA(hrdata_b), .PSEL(psel_b), .PADDR(paddr_b), .PWRITE(pwrite_b), .PENABLE(penable_b),
    .PWDATA(pwdata_b), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .TIMEOUT_EVT(tevt_b)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        slverr;
    logic [31:0] prdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_psel;
    int          exp_waits;
    int          exp_tevt;
  } vec_t;

  vec_t vecs [9];
  vec_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Starts an address phase on the current falling edge, plays the APB slave for instance A,
  // and returns on the falling edge where HREADYOUT comes back high (DONE or ERR2).
  task automatic do_xfer(input vec_t v, input string pfx);
    vec_t        e;
    int          waits, stall, tevt_cnt;
    logic [3:0]  psel_seen;
    logic [31:0] paddr_seen, pwdata_seen;
    logic        pwrite_seen, err1_seen;
    sb.push_back(v);
    hsel = 1'b1; hreadyin = 1'b1; htrans = HTRANS_NONSEQ; haddr = v.addr; hwrite = v.wr;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = v.wdata;
    waits = 0; stall = v.stall; tevt_cnt = 0; psel_seen = '0;
    paddr_seen = '0; pwdata_seen = '0; pwrite_seen = 1'b0; err1_seen = 1'b0;
    while (hro_a == 1'b0 && waits < 1500) begin
      if (psel_a != 4'd0) begin
        psel_seen   = psel_seen | psel_a;
        paddr_seen  = paddr_a;
        pwdata_seen = pwdata_a;
        pwrite_seen = pwrite_a;
      end
      if (tevt_a) tevt_cnt++;
      if (hresp_a) err1_seen = 1'b1;
      if (psel_a != 4'd0 && penable_a) begin
        if (stall > 0) begin
          pready = 1'b0; stall--;
        end else begin
          pready = 1'b1; pslverr = v.slverr; prdata = v.prdata;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      @(negedge clk);
      waits++;
    end
    pready = 1'b0; pslverr = 1'b0;
    if (tevt_a) tevt_cnt++;
    e = sb.pop_front();
    check({pfx, "_waits"}, waits, e.exp_waits);
    check({pfx, "_hresp"}, hresp_a, e.exp_resp);
    check({pfx, "_err1"}, err1_seen, e.exp_resp);
    check({pfx, "_hrdata"}, hrdata_a, e.exp_rdata);
    check({pfx, "_psel"}, psel_seen, e.exp_psel);
    check({pfx, "_tevt"}, tevt_cnt, e.exp_tevt);
    check({pfx, "_apb_idle"}, {psel_a, penable_a}, 5'd0);
    if (e.exp_psel != 16'd0) begin
      check({pfx, "_paddr"}, paddr_seen, e.addr);
      check({pfx, "_pwrite"}, pwrite_seen, e.wr);
      if (e.wr) check({pfx, "_pwdata"}, pwdata_seen, e.wdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t b0, b1, de;
    int   k;
    logic ok;

    //          wr    addr          wdata         stall slv  prdata        resp  rdata         psel    waits tevt
    vecs[0] = '{1'b1, 32'h02000010, 32'hDEADBEEF, 0,    1'b0, 32'h0,        1'b0, 32'h0,        16'h4, 3,  0};
    vecs[1] = '{1'b0, 32'h00000000, 32'h0,        4,    1'b0, 32'h12345678, 1'b0, 32'h12345678, 16'h1, 7,  0};
    vecs[2] = '{1'b1, 32'h01000004, 32'hCAFEF00D, 0,    1'b1, 32'h0,        1'b1, 32'h12345678, 16'h2, 4,  0};
    vecs[3] = '{1'b0, 32'h03000008, 32'h0,        2,    1'b0, 32'hA5A50F0F, 1'b0, 32'hA5A50F0F, 16'h8, 5,  0};
    vecs[4] = '{1'b0, 32'h05000000, 32'h0,        0,    1'b0, 32'h99999999, 1'b1, 32'h0,        16'h0, 2,  0};
    vecs[5] = '{1'b0, 32'h00000020, 32'h0,        7,    1'b0, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 16'h1, 10, 0};
    vecs[6] = '{1'b1, 32'h0300000C, 32'h11223344, 1,    1'b0, 32'h0,        1'b0, 32'h0BADF00D, 16'h8, 4,  0};
    vecs[7] = '{1'b0, 32'h01000100, 32'h0,        1,    1'b1, 32'h77777777, 1'b1, 32'h0,        16'h2, 5,  0};
    vecs[8] = '{1'b0, 32'h02000040, 32'h0,        1000, 1'b0, 32'h0,        1'b1, 32'h0,        16'h4, 11, 1};

    rst_n = 1'b0; hsel = 1'b0; hreadyin = 1'b1; haddr = '0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_hreadyout", hro_a, 1'b1);
    check("rst_hresp", hresp_a, 1'b0);
    check("rst_hrdata", hrdata_a, 32'h0);
    check("rst_psel_penable", {psel_a, penable_a, pwrite_a, tevt_a}, 7'd0);
    check("rst_paddr", paddr_a, 32'h0);
    check("rst_pwdata", pwdata_a, 32'h0);
    check("rst_b_hreadyout", hro_b, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // IDLE/BUSY while selected, or NONSEQ while unselected: no APB activity, zero wait.
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h01000000;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_NONSEQ;
    @(negedge clk);
    check("busy_no_wait", {hro_a, hresp_a}, 2'b10);
    htrans = HTRANS_IDLE;
    @(negedge clk);
    check("unsel_no_apb", {psel_a, penable_a, hro_a}, 6'b000001);

    for (int i = 0; i < 9; i++) begin
      do_xfer(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end
    check("sb_empty", sb.size(), 0);

    // Back-to-back: second address phase presented during DONE of the first.
    b0 = '{1'b1, 32'h01000000, 32'h55AA55AA, 0, 1'b0, 32'h0, 1'b0, 32'h0, 16'h2, 3, 0};
    b1 = '{1'b0, 32'h02000004, 32'h0, 0, 1'b0, 32'h600DCAFE, 1'b0, 32'h600DCAFE, 16'h4, 3, 0};
    do_xfer(b0, "b2b0");
    do_xfer(b1, "b2b1");
    @(negedge clk);

    // Transfer presented during ERR2 must be dropped.
    de = '{1'b0, 32'h05000010, 32'h0, 0, 1'b0, 32'h0, 1'b1, 32'h0, 16'h0, 2, 0};
    do_xfer(de, "decerr");
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h00000000; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE;
    ok = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (hro_a !== 1'b1 || psel_a !== 4'd0) ok = 1'b0;
      @(negedge clk);
    end
    check("err2_ignored", ok, 1'b1);

    // Reset asserted while in ACCESS clears outputs immediately.
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h03000000; hwrite = 1'b1;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFEEDFACE; pready = 1'b0;
    k = 0;
    while (penable_a !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reach_access", penable_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_apb", {psel_a, penable_a, pwrite_a}, 6'd0);
    check("rst_mid_ahb", {hro_a, hresp_a}, 2'b10);
    check("rst_mid_paddr", paddr_a, 32'h0);
    check("rst_mid_pwdata", pwdata_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_no_resp", {hro_a, hresp_a, psel_a}, 6'b100000);

    // TIMEOUT=0 on instance B: still stalled after 1000 cycles.
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h02000000; hwrite = 1'b0;
    @(negedge clk);
    hsel = 1'b0; htrans = HTRANS_IDLE; pready = 1'b0;
    repeat (1000) @(negedge clk);
    check("to0_b_hreadyout", hro_b, 1'b0);
    check("to0_b_penable", penable_b, 1'b1);
    check("to0_b_psel", psel_b, 16'h0004);
    check("to0_b_tevt", tevt_b, 1'b0);
    check("to0_a_aborted", {hro_a, hresp_a, penable_a}, 3'b100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("to0_b_after_rst", {hro_b, penable_b}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
